// File: rtl/game_flow_if.sv
// Game sequencer bus: frame/button/hit inputs, hero position,
// and the level, lives and overlay controls it hands back.
interface game_flow_if;
    logic        frame_tick;
    logic        start;
    logic        hero_hit;
    logic [11:0] hero_x_pos;
    logic [11:0] hero_y_pos;
    logic [3:0]  level;
    logic [2:0]  lives;
    logic        hero_rst;
    logic        freeze;
    logic        banner_on;
    logic        game_over;
    logic [2:0]  state;

    modport master (
        output frame_tick, start, hero_hit, hero_x_pos, hero_y_pos,
        input  level, lives, hero_rst, freeze, banner_on, game_over, state
    );

    modport slave (
        input  frame_tick, start, hero_hit, hero_x_pos, hero_y_pos,
        output level, lives, hero_rst, freeze, banner_on, game_over, state
    );
endinterface

// File: rtl/game_flow_controller.sv
// Binary Land game sequencer: title, banner, play, clear, death
// and game-over phases with level and life bookkeeping.
module game_flow_controller #(
    parameter int MAX_LEVEL     = 15,
    parameter int LIVES_INIT    = 3,
    parameter int BANNER_FRAMES = 120,
    parameter int DEATH_FRAMES  = 60,
    parameter int GOAL_X        = 481,
    parameter int GOAL_Y        = 108
) (
    input logic       clk,
    input logic       rst,
    game_flow_if.slave bus
);
    typedef enum logic [2:0] {
        TITLE  = 3'd0,
        BANNER = 3'd1,
        PLAY   = 3'd2,
        CLEAR  = 3'd3,
        DEATH  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam int MAXF = (BANNER_FRAMES > DEATH_FRAMES) ?
                          BANNER_FRAMES : DEATH_FRAMES;
    localparam int CW = $clog2(MAXF + 1);
    localparam logic [CW-1:0] BAN_LAST = CW'(BANNER_FRAMES - 1);
    localparam logic [CW-1:0] DTH_LAST = CW'(DEATH_FRAMES - 1);

    state_t        st;
    logic [CW-1:0] cnt;
    logic [3:0]    level;
    logic [2:0]    lives;
    logic          hero_rst;
    logic          freeze;
    logic          banner_on;
    logic          game_over;
    logic          goal;

    assign goal = (bus.hero_x_pos == 12'(GOAL_X)) &&
                  (bus.hero_y_pos == 12'(GOAL_Y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= TITLE;
            cnt       <= '0;
            level     <= '0;
            lives     <= 3'(LIVES_INIT);
            hero_rst  <= 1'b0;
            freeze    <= 1'b1;
            banner_on <= 1'b0;
            game_over <= 1'b0;
        end else begin
            hero_rst <= 1'b0;
            unique case (st)
                TITLE, OVER: begin
                    if (bus.start) begin
                        st        <= BANNER;
                        cnt       <= '0;
                        level     <= '0;
                        lives     <= 3'(LIVES_INIT);
                        hero_rst  <= 1'b1;
                        freeze    <= 1'b1;
                        banner_on <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                BANNER: begin
                    if (bus.frame_tick) begin
                        if (cnt == BAN_LAST) begin
                            st        <= PLAY;
                            cnt       <= '0;
                            freeze    <= 1'b0;
                            banner_on <= 1'b0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // goal outranks a simultaneous hit
                    if (goal) begin
                        st     <= CLEAR;
                        cnt    <= '0;
                        freeze <= 1'b1;
                    end else if (bus.hero_hit) begin
                        st     <= DEATH;
                        cnt    <= '0;
                        freeze <= 1'b1;
                    end
                end
                CLEAR: begin
                    st        <= BANNER;
                    cnt       <= '0;
                    level     <= (level == 4'(MAX_LEVEL)) ? 4'd0 : level + 4'd1;
                    hero_rst  <= 1'b1;
                    banner_on <= 1'b1;
                end
                DEATH: begin
                    if (bus.frame_tick) begin
                        if (cnt == DTH_LAST) begin
                            cnt <= '0;
                            if (lives != 3'd0)
                                lives <= lives - 3'd1;
                            if (lives <= 3'd1) begin
                                st        <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                st        <= BANNER;
                                hero_rst  <= 1'b1;
                                banner_on <= 1'b1;
                            end
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    st        <= TITLE;
                    cnt       <= '0;
                    freeze    <= 1'b1;
                    banner_on <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = st;
    assign bus.level     = level;
    assign bus.lives     = lives;
    assign bus.hero_rst  = hero_rst;
    assign bus.freeze    = freeze;
    assign bus.banner_on = banner_on;
    assign bus.game_over = game_over;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with hand-computed
// expectations for every phase transition.
module tb_game_flow_controller;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    game_flow_if gif ();

    game_flow_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            gif.frame_tick = 1'b1;
            step(1);
            gif.frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse_start();
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
    endtask

    task automatic do_clear();
        gif.hero_x_pos = 12'd481;
        gif.hero_y_pos = 12'd108;
        step(1);
        gif.hero_x_pos = 12'd0;
        gif.hero_y_pos = 12'd0;
        step(1);
        frames(120);
    endtask

    task automatic hit();
        gif.hero_hit = 1'b1;
        step(1);
        gif.hero_hit = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        gif.frame_tick = 1'b0;
        gif.start      = 1'b0;
        gif.hero_hit   = 1'b0;
        gif.hero_x_pos = 12'd0;
        gif.hero_y_pos = 12'd0;
        step(2);
        chk("rst_state", gif.state, 0);
        chk("rst_level", gif.level, 0);
        chk("rst_lives", gif.lives, 3);
        chk("rst_freeze", gif.freeze, 1);
        chk("rst_banner", gif.banner_on, 0);
        chk("rst_over", gif.game_over, 0);
        chk("rst_hrst", gif.hero_rst, 0);
        rst = 1'b0;
        step(2);

        pulse_start();
        chk("start_state", gif.state, 1);
        chk("start_hrst", gif.hero_rst, 1);
        chk("start_banner", gif.banner_on, 1);
        chk("start_level", gif.level, 0);
        chk("start_lives", gif.lives, 3);
        step(1);
        chk("hrst_once", gif.hero_rst, 0);
        frames(119);
        chk("ban119_state", gif.state, 1);
        frames(1);
        chk("ban120_state", gif.state, 2);
        chk("play_freeze", gif.freeze, 0);
        chk("play_banner", gif.banner_on, 0);

        gif.hero_x_pos = 12'd481;
        gif.hero_y_pos = 12'd108;
        step(1);
        chk("clr_state", gif.state, 3);
        chk("clr_level_old", gif.level, 0);
        gif.hero_x_pos = 12'd0;
        gif.hero_y_pos = 12'd0;
        step(1);
        chk("clr_ban_state", gif.state, 1);
        chk("clr_level_new", gif.level, 1);
        chk("clr_hrst", gif.hero_rst, 1);
        step(1);
        chk("clr_hrst_off", gif.hero_rst, 0);
        frames(120);
        chk("clr_play", gif.state, 2);

        hit();
        chk("die_state", gif.state, 4);
        chk("die_freeze", gif.freeze, 1);
        frames(59);
        chk("die59_state", gif.state, 4);
        chk("die59_lives", gif.lives, 3);
        frames(1);
        chk("die60_state", gif.state, 1);
        chk("die60_lives", gif.lives, 2);
        chk("die60_level", gif.level, 1);
        chk("die60_hrst", gif.hero_rst, 0);
        frames(120);
        chk("die_play", gif.state, 2);

        gif.hero_x_pos = 12'd481;
        gif.hero_y_pos = 12'd108;
        gif.hero_hit   = 1'b1;
        step(1);
        gif.hero_hit   = 1'b0;
        gif.hero_x_pos = 12'd0;
        gif.hero_y_pos = 12'd0;
        chk("both_state", gif.state, 3);
        step(1);
        chk("both_level", gif.level, 2);
        chk("both_lives", gif.lives, 2);

        frames(60);
        gif.start    = 1'b1;
        gif.hero_hit = 1'b1;
        step(1);
        gif.start    = 1'b0;
        gif.hero_hit = 1'b0;
        chk("ban_ignore", gif.state, 1);
        chk("ban_ign_hrst", gif.hero_rst, 0);
        frames(60);
        chk("ban_ign_play", gif.state, 2);

        for (int i = 0; i < 13; i++)
            do_clear();
        chk("lvl15", gif.level, 15);
        do_clear();
        chk("lvl_wrap", gif.level, 0);
        chk("wrap_play", gif.state, 2);

        hit();
        frames(60);
        chk("d2_lives", gif.lives, 1);
        frames(120);
        hit();
        frames(60);
        chk("over_state", gif.state, 5);
        chk("over_lives", gif.lives, 0);
        chk("over_flag", gif.game_over, 1);
        chk("over_hrst", gif.hero_rst, 0);
        chk("over_banner", gif.banner_on, 0);
        step(3);
        chk("over_hold", gif.state, 5);

        gif.hero_x_pos = 12'd481;
        gif.hero_y_pos = 12'd108;
        step(1);
        gif.hero_x_pos = 12'd0;
        gif.hero_y_pos = 12'd0;
        chk("over_goal_ign", gif.state, 5);

        pulse_start();
        chk("restart_state", gif.state, 1);
        chk("restart_lives", gif.lives, 3);
        chk("restart_level", gif.level, 0);
        chk("restart_hrst", gif.hero_rst, 1);
        chk("restart_over", gif.game_over, 0);
        frames(120);
        chk("restart_play", gif.state, 2);

        hit();
        frames(60);
        frames(120);
        do_clear();
        chk("pre_rst_level", gif.level, 1);
        chk("pre_rst_lives", gif.lives, 2);
        hit();
        frames(30);
        chk("mid_death", gif.state, 4);
        rst = 1'b1;
        #1;
        chk("arst_state", gif.state, 0);
        chk("arst_level", gif.level, 0);
        chk("arst_lives", gif.lives, 3);
        chk("arst_freeze", gif.freeze, 1);
        step(1);
        rst = 1'b0;
        frames(5);
        chk("title_ticks", gif.state, 0);
        pulse_start();
        frames(119);
        chk("rst_ban119", gif.state, 1);
        frames(1);
        chk("rst_ban120", gif.state, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
